// File: rtl/lse_simd_add_pipe.sv
// Two-stage log-space SIMD adder: low half summed in stage 1, high half in stage 2,
// with per-mode carry cutting, per-lane saturation and valid/ready flow control.
module lse_simd_add_pipe #(
   parameter int WIDTH = 24,
   parameter int LANES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic [1:0]       i_simd_mode,
   input  logic             i_sat_en,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [LANES-1:0] o_lane_carry,
   output logic [LANES-1:0] o_lane_sat,
   output logic             o_mode_err
);

   localparam int Q = WIDTH / 4;
   localparam logic [1:0] M_1X = 2'b00;
   localparam logic [1:0] M_2X = 2'b01;
   localparam logic [1:0] M_4X = 2'b10;
   localparam logic [1:0] M_ERR = 2'b11;

   // stage 1 state
   logic           s1_vld_q;
   logic [2*Q-1:0] s1_lo_q;
   logic           s1_cq_q, s1_ch_q;
   logic [2*Q-1:0] s1_a_hi_q, s1_b_hi_q;
   logic [1:0]     s1_mode_q;
   logic           s1_sat_q, s1_err_q;

   // stage 2 / output state
   logic             s2_vld_q;
   logic [WIDTH-1:0] res_q;
   logic [LANES-1:0] carry_q, sat_q;
   logic             err_q;

   logic adv1, adv2;
   assign adv2    = !s2_vld_q || i_ready;
   assign adv1    = !s1_vld_q || adv2;
   assign o_ready = adv1;

   // stage 1 low-half add, cut at WIDTH/4 in 4-lane mode
   logic [Q:0] q0_sum, q1_sum;
   logic       q1_cin;
   logic [1:0] mode_eff_d;
   always_comb begin
      q0_sum     = {1'b0, i_operand_a[Q-1:0]} + {1'b0, i_operand_b[Q-1:0]};
      q1_cin     = (i_simd_mode == M_4X) ? 1'b0 : q0_sum[Q];
      q1_sum     = {1'b0, i_operand_a[2*Q-1:Q]} + {1'b0, i_operand_b[2*Q-1:Q]}
                   + {{Q{1'b0}}, q1_cin};
      mode_eff_d = (i_simd_mode == M_ERR) ? M_1X : i_simd_mode;
   end

   // stage 2 high-half add, carry-in only crosses the midpoint in 1-lane mode
   logic [Q:0]       q2_sum, q3_sum;
   logic             q2_cin, q3_cin;
   logic [LANES-1:0] carry_d, sat_d;
   logic [3:0]       qsat;
   logic [WIDTH-1:0] res_d;
   always_comb begin
      q2_cin = (s1_mode_q == M_1X) ? s1_ch_q : 1'b0;
      q2_sum = {1'b0, s1_a_hi_q[Q-1:0]} + {1'b0, s1_b_hi_q[Q-1:0]} + {{Q{1'b0}}, q2_cin};
      q3_cin = (s1_mode_q == M_4X) ? 1'b0 : q2_sum[Q];
      q3_sum = {1'b0, s1_a_hi_q[2*Q-1:Q]} + {1'b0, s1_b_hi_q[2*Q-1:Q]}
               + {{Q{1'b0}}, q3_cin};
      carry_d = '0;
      qsat    = '0;
      case (s1_mode_q)
         M_1X: begin
            carry_d[0] = q3_sum[Q];
            qsat       = {4{q3_sum[Q]}};
         end
         M_2X: begin
            carry_d[1:0] = {q3_sum[Q], s1_ch_q};
            qsat         = {{2{q3_sum[Q]}}, {2{s1_ch_q}}};
         end
         default: begin
            carry_d[3:0] = {q3_sum[Q], q2_sum[Q], s1_ch_q, s1_cq_q};
            qsat         = carry_d[3:0];
         end
      endcase
      qsat  = s1_sat_q ? qsat : 4'b0;
      sat_d = s1_sat_q ? carry_d : '0;
      res_d = {q3_sum[Q-1:0], q2_sum[Q-1:0], s1_lo_q};
      for (int i = 0; i < 4; i++)
         if (qsat[i]) res_d[i*Q +: Q] = '1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_vld_q  <= 1'b0;
         s1_lo_q   <= '0;
         s1_cq_q   <= 1'b0;
         s1_ch_q   <= 1'b0;
         s1_a_hi_q <= '0;
         s1_b_hi_q <= '0;
         s1_mode_q <= M_1X;
         s1_sat_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         res_q     <= '0;
         carry_q   <= '0;
         sat_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (adv1) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
               s1_lo_q   <= {q1_sum[Q-1:0], q0_sum[Q-1:0]};
               s1_cq_q   <= q0_sum[Q];
               s1_ch_q   <= q1_sum[Q];
               s1_a_hi_q <= i_operand_a[WIDTH-1:2*Q];
               s1_b_hi_q <= i_operand_b[WIDTH-1:2*Q];
               s1_mode_q <= mode_eff_d;
               s1_sat_q  <= i_sat_en;
               s1_err_q  <= (i_simd_mode == M_ERR);
            end
         end
         if (adv2) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               res_q   <= res_d;
               carry_q <= carry_d;
               sat_q   <= sat_d;
               err_q   <= s1_err_q;
            end
         end
      end
   end

   assign o_valid      = s2_vld_q;
   assign o_result     = res_q;
   assign o_lane_carry = carry_q;
   assign o_lane_sat   = sat_q;
   assign o_mode_err   = err_q;

endmodule

// File: tb/tb_lse_simd_add_pipe.sv
// Scoreboard bench for lse_simd_add_pipe: lane-level arithmetic model, directed
// corner beats, backpressure, mid-stream reset and randomized traffic.
`timescale 1ns/1ps
module tb_lse_simd_add_pipe;
   localparam int W = 24;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   carry;
      logic [3:0]   sat;
      logic         err;
   } exp_t;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [W-1:0] i_operand_a = '0;
   logic [W-1:0] i_operand_b = '0;
   logic [1:0]   i_simd_mode = 2'b00;
   logic         i_sat_en = 1'b0;
   logic         o_valid;
   logic         i_ready = 1'b1;
   logic [W-1:0] o_result;
   logic [3:0]   o_lane_carry;
   logic [3:0]   o_lane_sat;
   logic         o_mode_err;

   lse_simd_add_pipe #(.WIDTH(W), .LANES(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
      .i_simd_mode(i_simd_mode), .i_sat_en(i_sat_en),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_lane_carry(o_lane_carry), .o_lane_sat(o_lane_sat), .o_mode_err(o_mode_err)
   );

   always #5 i_clk = ~i_clk;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic bp_force = 1'b0;
   logic rnd_ready = 1'b0;
   logic held_vld = 1'b0;
   exp_t held;
   logic saw_stall = 1'b0;

   // Reference: split each operand into lanes and add them as plain integers
   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m, logic s);
      exp_t   e;
      int     n, lw;
      longint mask, av, bv, sum, c;
      n = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
      lw = W / n;
      mask = (64'd1 << lw) - 1;
      e = '0;
      for (int l = 0; l < n; l++) begin
         av = (longint'(a) >> (l * lw)) & mask;
         bv = (longint'(b) >> (l * lw)) & mask;
         sum = av + bv;
         c = sum >> lw;
         e.res = e.res | W'(((s && c != 0) ? mask : (sum & mask)) << (l * lw));
         e.carry[l] = (c != 0);
         e.sat[l] = s && (c != 0);
      end
      e.err = (m == 2'b11);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge i_clk) begin
      #2;
      i_ready = bp_force ? 1'b0 : (rnd_ready ? ($urandom_range(3) != 0) : 1'b1);
   end

   // Monitor: sb holds exactly the beats currently inside the pipe
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         sb.delete();
         held_vld = 1'b0;
      end else begin
         chk("o_ready", 32'(o_ready), 32'((sb.size() < 2) || i_ready));
         if (!o_ready) saw_stall = 1'b1;
         if (held_vld) begin
            chk("hold_result", 32'(o_result), 32'(held.res));
            chk("hold_carry", 32'(o_lane_carry), 32'(held.carry));
            chk("hold_sat", 32'(o_lane_sat), 32'(held.sat));
            chk("hold_err", 32'(o_mode_err), 32'(held.err));
         end
         held_vld = o_valid && !i_ready;
         held = {o_result, o_lane_carry, o_lane_sat, o_mode_err};
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got result %0h expected none", o_result);
            end else begin
               e = sb.pop_front();
               chk("result", 32'(o_result), 32'(e.res));
               chk("lane_carry", 32'(o_lane_carry), 32'(e.carry));
               chk("lane_sat", 32'(o_lane_sat), 32'(e.sat));
               chk("mode_err", 32'(o_mode_err), 32'(e.err));
            end
         end
         if (i_valid && o_ready)
            sb.push_back(model(i_operand_a, i_operand_b, i_simd_mode, i_sat_en));
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] m, input logic s);
      logic took;
      took = 1'b0;
      i_valid = 1'b1;
      i_operand_a = a;
      i_operand_b = b;
      i_simd_mode = m;
      i_sat_en = s;
      for (int n = 0; n < 100 && !took; n++) begin
         @(negedge i_clk);
         took = o_ready;
         @(posedge i_clk);
         #1;
      end
      if (!took) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
      end
   endtask

   task automatic send_rand();
      send(W'($urandom), W'($urandom), 2'($urandom_range(3)), 1'($urandom_range(1)));
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge i_clk);
      #1;
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d beats pending expected 0", sb.size());
      end
   endtask

   task automatic chk_idle(input string tag);
      @(negedge i_clk);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_ready"}, 32'(o_ready), 32'd1);
      chk({tag, "_result"}, 32'(o_result), 32'd0);
      chk({tag, "_carry"}, 32'(o_lane_carry), 32'd0);
      chk({tag, "_sat"}, 32'(o_lane_sat), 32'd0);
      chk({tag, "_err"}, 32'(o_mode_err), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      chk_idle("reset");

      // corner beats
      send(24'hFFFFFF, 24'h000001, 2'b00, 1'b0);
      send(24'hFFFFFF, 24'h000001, 2'b00, 1'b1);
      send(24'h00003F, 24'h000001, 2'b10, 1'b0);
      send(24'h03F000, 24'h001000, 2'b10, 1'b0);
      send(24'h800800, 24'h800800, 2'b01, 1'b1);
      send(24'h800800, 24'h800800, 2'b01, 1'b0);
      send(24'h000FFF, 24'h000001, 2'b11, 1'b0);
      send(24'hFC0FC0, 24'h0410C1, 2'b10, 1'b1);
      i_valid = 1'b0;
      drain();

      // i_ready low for 3 cycles from the first o_valid
      saw_stall = 1'b0;
      fork
         begin
            repeat (4) send_rand();
            i_valid = 1'b0;
         end
         begin
            int n;
            n = 0;
            do begin
               @(posedge i_clk);
               #1;
               n++;
            end while (!o_valid && n < 50);
            if (!o_valid) begin
               vectors++;
               miscompares++;
               $display("FAIL bp_wait: got o_valid 0 expected 1 within 50 cycles");
            end
            bp_force = 1'b1;
            repeat (3) @(posedge i_clk);
            #1 bp_force = 1'b0;
         end
      join
      drain();
      chk("bp_stall_seen", 32'(saw_stall), 32'd1);

      // reset with both stages full; a beat offered during reset must be dropped
      bp_force = 1'b1;
      @(posedge i_clk);
      #1;
      repeat (3) begin
         i_valid = 1'b1;
         i_operand_a = W'($urandom);
         i_operand_b = W'($urandom);
         i_simd_mode = 2'($urandom_range(3));
         i_sat_en = 1'($urandom_range(1));
         @(posedge i_clk);
         #1;
      end
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      i_valid = 1'b0;
      bp_force = 1'b0;
      chk_idle("midrst");
      repeat (4) @(posedge i_clk);
      #1;

      // randomized traffic with random backpressure and bubbles
      rnd_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(4) == 0) begin
            i_valid = 1'b0;
            @(posedge i_clk);
            #1;
         end
         send_rand();
      end
      i_valid = 1'b0;
      drain();
      rnd_ready = 1'b0;
      repeat (3) @(posedge i_clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lse_simd_add_pipe.md
LSE_SIMD_ADD_PIPE -- requirements
Module: lse_simd_add_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 24, operand/result width; legal values are multiples of 4, at least 8.
REQ-002 SHALL provide parameter LANES, fixed at 4, width of the lane-carry and lane-saturation vectors.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_clk  input  1  rising-edge clock.
REQ-004 SHALL have i_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have i_valid  input  1  upstream beat valid.
REQ-006 SHALL have o_ready  output  1  block can accept a beat this cycle.
REQ-007 SHALL have i_operand_a  input  WIDTH  log-space operand A.
REQ-008 SHALL have i_operand_b  input  WIDTH  log-space operand B.
REQ-009 SHALL have i_simd_mode  input  2  00: 1xWIDTH, 01: 2x(WIDTH/2), 10: 4x(WIDTH/4), 11: illegal.
REQ-010 SHALL have i_sat_en  input  1  per-beat saturation enable.
REQ-011 SHALL have o_valid  output  1  result beat valid.
REQ-012 SHALL have i_ready  input  1  downstream accepts the result.
REQ-013 SHALL have o_result  output  WIDTH  lane-wise sum, saturated if enabled.
REQ-014 SHALL have o_lane_carry  output  LANES  raw carry-out per active lane, LSB = lane 0; inactive lanes 0.
REQ-015 SHALL have o_lane_sat  output  LANES  lane was saturated this beat.
REQ-016 SHALL have o_mode_err  output  1  beat was issued with mode 11.

Function
REQ-017 SHALL transfer an input beat when i_valid && o_ready, and an output beat when o_valid && i_ready.
REQ-018 SHALL be a 2-stage pipeline, latency 2 cycles from accept to o_valid, throughput one beat per cycle.
REQ-019 Stage 1 SHALL add bits [WIDTH/2-1:0] and register: the low sum, the carries at WIDTH/4 and WIDTH/2, the high operand halves, the mode, sat_en and mode_err.
REQ-020 Stage 2 SHALL add bits [WIDTH-1:WIDTH/2], with carry-in = the registered carry at WIDTH/2 in mode 00, else 0.
REQ-021 Carry SHALL be cut (forced 0) at bit WIDTH/2 in modes 01/10, and at bits WIDTH/4 and 3*WIDTH/4 in mode 10.
REQ-022 Lane carry mapping SHALL be as follows:
- mode 00: [0] = carry(WIDTH).
- mode 01: [0] = carry(WIDTH/2), [1] = carry(WIDTH).
- mode 10: [3:0] = carries at WIDTH/4, WIDTH/2, 3*WIDTH/4, WIDTH.
REQ-023 Mode 11 SHALL compute as mode 00, with o_mode_err = 1 on that beat.
REQ-024 When sat_en = 1 and a lane's carry = 1, that lane's result bits SHALL be all ones and its o_lane_sat bit = 1; o_lane_carry still reports the raw carry.
REQ-025 When sat_en = 0, the result SHALL wrap modulo 2^lane_width and o_lane_sat = 0.
REQ-026 Each stage SHALL advance when it is empty or the next stage advances; o_ready = !s1_valid || !s2_valid || i_ready (combinational from i_ready permitted).
REQ-027 While o_valid && !i_ready, o_result, o_lane_carry, o_lane_sat and o_mode_err SHALL hold stable.
REQ-028 Mode and sat_en SHALL be sampled per beat; a mode change between consecutive beats SHALL need no bubble.
REQ-029 i_valid deasserted SHALL insert a bubble; o_valid SHALL never assert for a non-accepted beat.

Reset
REQ-030 On i_rst = 1 at a clock edge, both stage valids SHALL clear; all outputs except o_ready SHALL be 0 on the following cycle.
REQ-031 o_ready SHALL be 1 one cycle after reset; in-flight beats SHALL be discarded without output.
REQ-032 A beat presented during the reset cycle SHALL NOT be accepted.

Verification (WIDTH = 24)
REQ-033 Mode 00, A = 0xFFFFFF, B = 0x000001, sat 0 -> after 2 cycles result 0x000000, lane_carry 0001; with sat 1 -> 0xFFFFFF, lane_sat 0001.
REQ-034 Mode 10, A = 0x00003F, B = 0x000001, sat 0 -> result 0x000000, lane_carry 0001 (no ripple into bit 6); A = 0x03F000, B = 0x001000 -> result 0x000000, lane_carry 0100.
REQ-035 Mode 01, A = B = 0x800800, sat 1 -> result 0xFFFFFF, lane_carry 0011, lane_sat 0011; same with sat 0 -> 0x000000.
REQ-036 Mode 11, A = 0x000FFF, B = 0x000001 -> result 0x001000, o_mode_err 1, lane_carry 0000.
REQ-037 Backpressure: stream 4 beats with i_ready low for 3 cycles from the first o_valid -> o_ready low once both stages are full, outputs stable, no beat lost or duplicated, order preserved.
REQ-038 Reset asserted with both stages full -> next cycle o_valid 0, o_ready 1, and no stale result appears afterwards.
